modmul: RTL and testbench

Pipelined bit-parallel modular multiplier over GF(29). It takes two 5-bit operands and produces their product reduced modulo 29. It accepts one operand pair per clock and delivers the result a fixed 3 cycles later. It is a self-contained arithmetic datapath block with no handshake, intended to sit inside a larger pipelined datapath.

---
 rtl/modmul_if.sv | 10 +
 rtl/modmul.sv | 60 ++++++
 tb/tb_modmul.sv | 113 +++++++++++
 3 files changed

// File: rtl/modmul_if.sv
// Operand/result bundle for the GF(29) multiplier.
// The master drives the operands and the slave returns the product.
interface modmul_if;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] m;

    modport master (output a, output b, input m);
    modport slave  (input a, input b, output m);
endinterface

// File: rtl/modmul.sv
// Three-stage pipelined bit-parallel multiplier over GF(29).
// Computes m = (a*b) mod 29; inputs captured at edge k appear on m after edge k+2.
module modmul (
    input  logic      clk,
    input  logic      reset,
    modmul_if.slave   bus
);
    logic [4:0] a_q, b_q;
    logic [6:0] p0_d, p0_q;
    logic [5:0] p1_d, p1_q;
    logic [4:0] m_d, m_q;

    logic [4:0] a_red;
    logic [4:0] t   [5];
    logic [4:0] sel [5];
    logic [5:0] dbl;
    logic [7:0] sum, r1, r2;

    // Stage 1 -> 2: canonicalise a, build a*2^i mod 29 by doubling, select by b
    always_comb begin
        a_red = (a_q >= 5'd29) ? 5'(a_q - 5'd29) : a_q;
        dbl   = '0;
        t[0]  = a_red;
        for (int unsigned i = 1; i < 5; i++) begin
            dbl  = {t[i-1], 1'b0};
            t[i] = (dbl >= 6'd29) ? 5'(dbl - 6'd29) : dbl[4:0];
        end
        for (int unsigned i = 0; i < 5; i++) begin
            sel[i] = b_q[i] ? t[i] : '0;
        end
        p0_d = 7'(sel[0]) + 7'(sel[1]) + 7'(sel[2]);
        p1_d = 6'(sel[3]) + 6'(sel[4]);
    end

    // Stage 2 -> 3: sum is at most 140, so subtracting 4*29, 2*29, 29 canonicalises it
    always_comb begin
        sum = 8'(p0_q) + 8'(p1_q);
        r1  = (sum >= 8'd116) ? sum - 8'd116 : sum;
        r2  = (r1 >= 8'd58) ? r1 - 8'd58 : r1;
        m_d = (r2 >= 8'd29) ? 5'(r2 - 8'd29) : r2[4:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            p0_q <= '0;
            p1_q <= '0;
            m_q  <= '0;
        end else begin
            a_q  <= bus.a;
            b_q  <= bus.b;
            p0_q <= p0_d;
            p1_q <= p1_d;
            m_q  <= m_d;
        end
    end

    assign bus.m = m_q;
endmodule

// File: tb/tb_modmul.sv
// Randomised and directed bench for modmul against a queue-based reference.
// Inputs change on the falling edge; m is sampled on the falling edge.
module tb_modmul;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$] = '{0, 0, 0};

    modmul_if bus ();

    modmul dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: each edge either flushes the in-flight results or enqueues a new product.
    always @(posedge clk) begin
        if (reset) begin
            exp_q = '{0, 0, 0};
        end else begin
            exp_q.push_front((int'(bus.a) * int'(bus.b)) % 29);
            void'(exp_q.pop_back());
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one operand pair for one edge, then check m against the model and the range.
    task automatic cycle(input logic [4:0] a, input logic [4:0] b, input logic r);
        bus.a = a;
        bus.b = b;
        reset = r;
        @(posedge clk);
        @(negedge clk);
        check("model", 32'(bus.m), 32'(exp_q[2]));
        check("range", {31'b0, (bus.m >= 5'd29)}, 32'd0);
    endtask

    logic [4:0] da [6] = '{5'd17, 5'd28, 5'd29, 5'd30, 5'd31, 5'd0};
    logic [4:0] db [6] = '{5'd13, 5'd28, 5'd5,  5'd30, 5'd31, 5'd31};
    int         dm [6] = '{18, 1, 0, 1, 4, 0};

    initial begin
        bus.a = '0;
        bus.b = '0;
        @(negedge clk);

        // Reset held for two edges, then released with zero operands
        cycle(5'd0, 5'd0, 1'b1);
        check("reset_m0", 32'(bus.m), 32'd0);
        cycle(5'd0, 5'd0, 1'b1);
        check("reset_m1", 32'(bus.m), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(5'd0, 5'd0, 1'b0);
            check("post_reset", 32'(bus.m), 32'd0);
        end

        // Directed values held for three edges
        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < 3; k++) cycle(da[i], db[i], 1'b0);
            check($sformatf("dir_%0dx%0d", da[i], db[i]), 32'(bus.m), 32'(dm[i]));
        end

        // Exhaustive sweep, a fastest
        for (int bi = 0; bi < 32; bi++) begin
            for (int ai = 0; ai < 32; ai++) begin
                cycle(5'(ai), 5'(bi), 1'b0);
            end
        end

        // Streaming three back-to-back operations
        cycle(5'd3, 5'd4, 1'b0);
        cycle(5'd5, 5'd6, 1'b0);
        cycle(5'd31, 5'd2, 1'b0);
        check("stream0", 32'(bus.m), 32'd12);
        cycle(5'd0, 5'd0, 1'b0);
        check("stream1", 32'(bus.m), 32'd1);
        cycle(5'd0, 5'd0, 1'b0);
        check("stream2", 32'(bus.m), 32'd4);

        // Reset mid-stream with nonzero work in flight
        cycle(5'd7, 5'd9, 1'b0);
        cycle(5'd11, 5'd13, 1'b0);
        cycle(5'd19, 5'd23, 1'b0);
        cycle(5'd25, 5'd27, 1'b1);
        check("midrst_m", 32'(bus.m), 32'd0);
        cycle(5'd6, 5'd7, 1'b0);
        check("flush1", 32'(bus.m), 32'd0);
        cycle(5'd0, 5'd0, 1'b0);
        check("flush2", 32'(bus.m), 32'd0);
        cycle(5'd0, 5'd0, 1'b0);
        check("after_rst", 32'(bus.m), 32'd13);

        // Random streaming with occasional resets
        for (int i = 0; i < 2000; i++) begin
            cycle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
